// File: rtl/vga_pkg.sv
// Shared VGA raster constants and helpers, used by vga_sync_gen, font_test_gen
// and the maze renderer.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 8;

    // Default 640x480 @ 60 Hz timing, in pixels and lines.
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_CLK_DIV = 2;

    // True when pos lies in [first, first+len-1].
    function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                       input int unsigned first,
                                       input int unsigned len);
        int unsigned p;
        p = {{(32-COORD_W){1'b0}}, pos};
        return (p >= first) && (p < first + len);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate divider: p_tick is high for one clk out of every CLK_DIV.
module vga_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    // A 1-bit counter is kept even at CLK_DIV=1 so the ports stay uniform.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: scan counters, registered syncs, video_on and frame strobes.
// Optional frame counter is enabled with `define VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_tick,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);

    localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_timing
            $fatal(1, "vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    logic [COORD_W-1:0] h_count_q;
    logic [COORD_W-1:0] h_count_d;
    logic [COORD_W-1:0] v_count_q;
    logic [COORD_W-1:0] v_count_d;
    logic               hsync_q;
    logic               hsync_d;
    logic               vsync_q;
    logic               vsync_d;

    // Syncs are decoded from the next counts so they land on the same edge.
    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (p_tick) begin
            if (h_count_q == H_LAST) begin
                h_count_d = '0;
                if (v_count_q == V_LAST) begin
                    v_count_d = '0;
                end else begin
                    v_count_d = v_count_q + 1'b1;
                end
            end else begin
                h_count_d = h_count_q + 1'b1;
            end
        end
        hsync_d = !in_window(h_count_d, HS_FIRST, H_SYNC);
        vsync_d = !in_window(v_count_d, VS_FIRST, V_SYNC);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_count_q <= '0;
            v_count_q <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign pixel_x    = h_count_q;
    assign pixel_y    = v_count_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    assign frame_tick = p_tick && (h_count_q == H_LAST) && (v_count_q == V_LAST);

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic [7:0] frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'h00;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing, small and tiny (CLK_DIV=1) instances
// scored every cycle against a closed-form raster model.
module tb_vga_sync_gen;

  localparam int SM_HT = 32;
  localparam int SM_VT = 20;
  localparam int SM_FRAME_CLK = SM_HT * SM_VT * 2;
  localparam int TN_FRAME_CLK = 8 * 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  logic       def_hsync, def_vsync, def_von, def_pt, def_ft;
  logic [9:0] def_x, def_y;
  logic [7:0] def_fc;
  logic       sm_hsync, sm_vsync, sm_von, sm_pt, sm_ft;
  logic [9:0] sm_x, sm_y;
  logic [7:0] sm_fc;
  logic       tn_hsync, tn_vsync, tn_von, tn_pt, tn_ft;
  logic [9:0] tn_x, tn_y;
  logic [7:0] tn_fc;

  vga_sync_gen dut_def (
    .clk(clk), .reset_n(reset_n), .hsync(def_hsync), .vsync(def_vsync),
    .video_on(def_von), .p_tick(def_pt), .pixel_x(def_x), .pixel_y(def_y),
    .frame_tick(def_ft), .frame_cnt(def_fc)
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .CLK_DIV(2)
  ) dut_sm (
    .clk(clk), .reset_n(reset_n), .hsync(sm_hsync), .vsync(sm_vsync),
    .video_on(sm_von), .p_tick(sm_pt), .pixel_x(sm_x), .pixel_y(sm_y),
    .frame_tick(sm_ft), .frame_cnt(sm_fc)
  );

  vga_sync_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(1)
  ) dut_tn (
    .clk(clk), .reset_n(reset_n), .hsync(tn_hsync), .vsync(tn_vsync),
    .video_on(tn_von), .p_tick(tn_pt), .pixel_x(tn_x), .pixel_y(tn_y),
    .frame_tick(tn_ft), .frame_cnt(tn_fc)
  );

  logic [32:0] obs_def, obs_sm, obs_tn;
  assign obs_def = {def_hsync, def_vsync, def_von, def_pt, def_ft, def_x, def_y, def_fc};
  assign obs_sm  = {sm_hsync, sm_vsync, sm_von, sm_pt, sm_ft, sm_x, sm_y, sm_fc};
  assign obs_tn  = {tn_hsync, tn_vsync, tn_von, tn_pt, tn_ft, tn_x, tn_y, tn_fc};

  logic [32:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int t = 0;
  int cycles = 0;
  int tn_ticks = 0;
  int sm_ticks = 0;
  int sm_last_tick = -1;

  // Expected outputs t active edges after the last edge that sampled reset low.
  function automatic logic [32:0] model(input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb,
                                        input int d, input int tt);
    int ht, vt, pix, dv, h, line, v, fr, fc;
    logic hsy, vsy, von, pt, ft;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    pix  = tt / d;
    dv   = tt % d;
    h    = pix % ht;
    line = pix / ht;
    v    = line % vt;
    fr   = line / vt;
    pt   = (dv == d - 1);
    ft   = pt && (h == ht - 1) && (v == vt - 1);
    hsy  = !((h >= hd + hf) && (h < hd + hf + hs));
    vsy  = !((v >= vd + vf) && (v < vd + vf + vs));
    von  = (h < hd) && (v < vd);
`ifdef VGA_SYNC_FRAME_CNT_EN
    fc = fr % 256;
`else
    fc = 0;
`endif
    return {hsy, vsy, von, pt, ft, 10'(h), 10'(v), 8'(fc)};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    if (failures > 200) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  // One clk: push model expectations at the edge, pop and compare half a cycle later.
  task automatic step();
    @(posedge clk);
    if (!reset_n) t = 0;
    else t++;
    exp_q.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 2, t));
    exp_q.push_back(model(16, 4, 6, 6, 12, 2, 2, 4, 2, t));
    exp_q.push_back(model(4, 1, 2, 1, 2, 1, 1, 1, 1, t));
    @(negedge clk);
    cycles++;
    chk("sb_def", obs_def, exp_q.pop_front());
    chk("sb_sm", obs_sm, exp_q.pop_front());
    chk("sb_tn", obs_tn, exp_q.pop_front());
    if (!reset_n) sm_last_tick = -1;
    if (tn_ft === 1'b1) tn_ticks++;
    if (sm_ft === 1'b1) begin
      sm_ticks++;
      chk("sm_tick_pos", {sm_x, sm_y}, {10'd31, 10'd19});
      if (sm_last_tick >= 0) chk("sm_tick_period", 33'(cycles - sm_last_tick), 33'(SM_FRAME_CLK));
      sm_last_tick = cycles;
    end
  endtask

  initial begin
    int n;
    logic prev;

    // Reset held for 3 clk.
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_x", 33'(def_x), 33'd0);
    chk("rst_y", 33'(def_y), 33'd0);
    chk("rst_syncs", {def_hsync, def_vsync}, 33'b11);
    chk("rst_video_on", 33'(def_von), 33'd1);
    chk("rst_p_tick", {def_pt, def_ft}, 33'd0);
    chk("rst_frame_cnt", 33'(def_fc), 33'd0);

    // Release: p_tick after CLK_DIV-1 edges, first pixel advance at CLK_DIV edges.
    reset_n = 1'b1;
    step();
    chk("first_p_tick", {def_pt, def_x}, {1'b1, 10'd0});
    step();
    chk("first_advance", {def_pt, def_x}, {1'b0, 10'd1});

    // hsync falls exactly as pixel_x becomes 656 and stays low 192 clk.
    n = 0;
    prev = def_hsync;
    while (def_x != 10'd656 && n < 2000) begin
      prev = def_hsync;
      step();
      n++;
    end
    chk("hsync_fall_x", 33'(def_x), 33'd656);
    chk("hsync_fall_edge", {prev, def_hsync}, 33'b10);
    n = 0;
    while (def_hsync == 1'b0 && n < 400) begin
      step();
      n++;
    end
    chk("hsync_low_clk", 33'(n), 33'd192);
    chk("hsync_rise_x", 33'(def_x), 33'd752);

    // Line wrap 799 -> 0 with pixel_y incrementing on the same edge.
    n = 0;
    while (def_x != 10'd799 && n < 200) begin
      step();
      n++;
    end
    chk("reach_799", 33'(def_x), 33'd799);
    n = 0;
    while (def_x == 10'd799 && n < 4) begin
      step();
      n++;
    end
    chk("wrap_xy", {def_x, def_y}, {10'd0, 10'd1});

    // Small instance: vsync low only on lines 14 and 15 (2 lines * 32 px * 2 clk).
    n = 0;
    while (sm_vsync != 1'b0 && n < 3000) begin
      step();
      n++;
    end
    chk("vsync_fall_y", {sm_vsync, sm_y, sm_x}, {1'b0, 10'd14, 10'd0});
    n = 0;
    while (sm_vsync == 1'b0 && n < 400) begin
      step();
      n++;
    end
    chk("vsync_low_clk", 33'(n), 33'd128);
    chk("vsync_rise_y", 33'(sm_y), 33'd16);

    // Run the tiny instance through 257 frames; frame_tick once per frame.
    n = 0;
    while (tn_ticks < 257 && n < 12000) begin
      step();
      n++;
    end
    chk("tn_257_ticks", 33'(tn_ticks), 33'd257);
    chk("tn_tick_time", 33'(t), 33'(257 * TN_FRAME_CLK - 1));
    chk("sm_tick_count", 33'(sm_ticks), 33'((t + 1) / SM_FRAME_CLK));
    step();
    chk("tn_after_tick_xy", {tn_x, tn_y}, 33'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("tn_frame_cnt_wrap", 33'(tn_fc), 33'd1);
`else
    chk("tn_frame_cnt_tied", 33'(tn_fc), 33'd0);
`endif

    // Mid-frame reset while the small instance is inside its hsync pulse.
    n = 0;
    while (!(sm_x == 10'd24 && sm_y == 10'd10) && n < 3000) begin
      step();
      n++;
    end
    chk("mid_pos", {sm_x, sm_y, sm_hsync}, {10'd24, 10'd10, 1'b0});
    reset_n = 1'b0;
    step();
    chk("mid_rst_sm", {sm_x, sm_y, sm_hsync, sm_vsync}, {10'd0, 10'd0, 2'b11});
    chk("mid_rst_def", {def_x, def_y, def_hsync, def_pt}, {10'd0, 10'd0, 1'b1, 1'b0});
    reset_n = 1'b1;
    step();
    chk("mid_first_p_tick", {sm_pt, sm_x}, {1'b1, 10'd0});
    step();
    chk("mid_first_advance", {sm_pt, sm_x}, {1'b0, 10'd1});
    for (int i = 0; i < 1500; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
